gpio_ctrl_irq: RTL
==================

Name: gpio_ctrl_irq

Overview:
Parametrised GPIO controller for the RISC-V MCU. It replaces fixed-width GPIO wiring with a register-mapped block that provides:
- per-pin direction and output data,
- atomic set and clear of output bits,
- synchronised input sampling,
- per-pin rising and falling edge interrupt capture with write-1-to-clear status, plus one combined irq line to the core.

It sits on the MCU peripheral bus and drives the gpio_output and gpio_direction top-level pins.

Parameters:
NUM_GPIO, 32, number of pins (1..32); register bits at and above NUM_GPIO read 0 and ignore writes.
SYNC_STAGES, 2, input synchroniser depth (>=2).

Ports:
clock  input  1  system clock; all logic rising-edge.
reset  input  1  synchronous, active-high reset.
bus_req  input  1  single-cycle access strobe.
bus_we  input  1  1 = write, 0 = read; qualified by bus_req.
bus_addr  input  5  byte address; word-aligned, bits [1:0] ignored.
bus_wdata  input  32  write data.
bus_ready  output  1  one-cycle acknowledge.
bus_rdata  output  32  read data; valid while bus_ready is 1.
gpio_input  input  NUM_GPIO  asynchronous pad inputs.
gpio_output  output  NUM_GPIO  output data register.
gpio_direction  output  NUM_GPIO  1 = pin driven as output.
irq  output  1  OR of all IRQ_STATUS bits.

Behaviour:
- Reset: every register, synchroniser flop, edge-history flop and output is 0. This covers gpio_output, gpio_direction, irq, bus_ready and bus_rdata.
- Register map:
  - 0x00 DATA_OUT, RW.
  - 0x04 DIR, RW.
  - 0x08 DATA_IN, RO (synchronised inputs).
  - 0x0C OUT_SET, WO: write 1 sets DATA_OUT bits; reads 0.
  - 0x10 OUT_CLR, WO: write 1 clears DATA_OUT bits; reads 0.
  - 0x14 RISE_EN, RW.
  - 0x18 FALL_EN, RW.
  - 0x1C IRQ_STATUS, read / write-1-to-clear.
- Unmapped addresses: read 0, writes ignored, bus_ready still asserted.
- Bus timing:
  - bus_req at edge k gives bus_ready=1 and valid bus_rdata for exactly the cycle after edge k+1; bus_rdata is 0 when bus_ready is 0.
  - Write effects are visible from edge k+1.
  - bus_req may be asserted every cycle; each request gets its own ack one cycle later.
  - Reset with an access in flight suppresses the pending ack.
- gpio_output mirrors DATA_OUT directly; gpio_direction mirrors DIR directly. No tristate logic lives in this block.
- Input path:
  - gpio_input passes through a SYNC_STAGES flop chain to form sync.
  - prev is sync delayed by one clock.
  - rise = sync & ~prev; fall = ~sync & prev.
  - Edge detection runs on all pins regardless of DIR, so output loopback is observable.
- Latency: a gpio_input change settled before edge n appears in DATA_IN after edge n+SYNC_STAGES-1. The matching IRQ_STATUS bit sets at edge n+SYNC_STAGES. irq is the combinational OR of IRQ_STATUS, with no extra delay.
- Status update per bit, each clock:
  - status_next = (status & ~w1c) | (rise & RISE_EN) | (fall & FALL_EN).
  - If an edge and a W1C land on the same bit in the same cycle, set wins.
  - Clearing RISE_EN or FALL_EN does not clear an already-set status bit.
  - Status bits are sticky until W1C or reset.
- OUT_SET and OUT_CLR are single-operation read-modify-write; only one bus write can occur per cycle, so they never conflict.
- A pulse shorter than one clock period may be missed; this is accepted behaviour.
- Pins at and above NUM_GPIO are unimplemented: they never set status and always read 0.

Test Plan:
- Reset: hold reset for 10 clocks with random gpio_input -> gpio_output=0, gpio_direction=0, irq=0, bus_ready=0; all registers read 0 after release.
- Bus access: write 0xA5A5_A5A5 to 0x00, then read 0x00 -> gpio_output=0xA5A5_A5A5 after edge k+1; bus_ready high exactly one cycle; rdata=0xA5A5_A5A5. Read 0x0C -> 0.
- Atomic output: DATA_OUT=0x0000_00F0, write OUT_SET=0x0F, then write OUT_CLR=0x30 -> gpio_output=0xFF, then 0xCF. Back-to-back requests give two acks on consecutive cycles.
- Edge interrupts, SYNC_STAGES=2: RISE_EN=0x1, FALL_EN=0x2.
  - Raise gpio_input[0] -> DATA_IN[0]=1 after 2 edges; IRQ_STATUS=0x1 and irq=1 after 3 edges.
  - Raise then lower bit 1 -> status bit 1 sets only on the fall.
  - Write 0x3 to 0x1C -> status=0, irq=0.
- Simultaneous set/clear: time the W1C of bit 0 so it lands on the edge where a new rising edge on pin 0 is detected -> bit 0 remains 1.
- Parameter sweep: NUM_GPIO=8 -> writing 0xFFFF_FFFF to DIR reads back 0xFF; edges forced on unimplemented pins do not set status.
- Mid-operation reset: reset asserted while IRQ_STATUS=0x3 and a read is pending -> status=0, irq=0, no ack issued.

Source files
------------

// File: rtl/gpio_ctrl_irq.sv
// gpio_ctrl_irq: register-mapped GPIO with synchronised inputs and edge interrupts
module gpio_ctrl_irq #(
  parameter int NUM_GPIO    = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                bus_req,
  input  logic                bus_we,
  input  logic [4:0]          bus_addr,
  input  logic [31:0]         bus_wdata,
  output logic                bus_ready,
  output logic [31:0]         bus_rdata,
  input  logic [NUM_GPIO-1:0] gpio_input,
  output logic [NUM_GPIO-1:0] gpio_output,
  output logic [NUM_GPIO-1:0] gpio_direction,
  output logic                irq
);
  localparam int N = NUM_GPIO;
  logic          req_q, req_d, we_q, we_d, ready_q, ready_d, wr;
  logic [2:0]    addr_q, addr_d;
  logic [N-1:0]  wdata_q, wdata_d;
  logic [N-1:0]  sync_q [SYNC_STAGES];
  logic [N-1:0]  sync_d [SYNC_STAGES];
  logic [N-1:0]  prev_q, prev_d, dout_q, dout_d, dir_q, dir_d;
  logic [N-1:0]  ren_q, ren_d, fen_q, fen_d, status_q, status_d;
  logic [N-1:0]  sync, rise, fall, w1c;
  logic [31:0]   rdata_q, rdata_d, rd_val;
  logic          unused_ok;
  assign unused_ok      = ^bus_addr[1:0];
  assign sync           = sync_q[SYNC_STAGES-1];
  assign rise           = sync & ~prev_q;
  assign fall           = ~sync & prev_q;
  assign gpio_output    = dout_q;
  assign gpio_direction = dir_q;
  assign irq            = |status_q;
  assign bus_ready      = ready_q;
  assign bus_rdata      = rdata_q;
  // Capture the request; it executes and acks on the following edge
  always_comb begin
    req_d   = bus_req;
    we_d    = bus_we;
    addr_d  = bus_addr[4:2];
    wdata_d = bus_wdata[N-1:0];
  end
  // Input synchroniser chain plus one cycle of history for edge detection
  always_comb begin
    sync_d[0] = gpio_input;
    for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
    prev_d = sync;
  end
  // Register writes and sticky status where a new edge beats a same-cycle clear
  always_comb begin
    wr       = req_q & we_q;
    dout_d   = wr && addr_q == 3'd0 ? wdata_q :
               wr && addr_q == 3'd3 ? dout_q | wdata_q :
               wr && addr_q == 3'd4 ? dout_q & ~wdata_q : dout_q;
    dir_d    = wr && addr_q == 3'd1 ? wdata_q : dir_q;
    ren_d    = wr && addr_q == 3'd5 ? wdata_q : ren_q;
    fen_d    = wr && addr_q == 3'd6 ? wdata_q : fen_q;
    w1c      = wr && addr_q == 3'd7 ? wdata_q : '0;
    status_d = (status_q & ~w1c) | (rise & ren_q) | (fall & fen_q);
  end
  // Read mux over the word index; write-only registers read as zero
  always_comb begin
    case (addr_q)
      3'd0:    rd_val = 32'(dout_q);
      3'd1:    rd_val = 32'(dir_q);
      3'd2:    rd_val = 32'(sync);
      3'd5:    rd_val = 32'(ren_q);
      3'd6:    rd_val = 32'(fen_q);
      3'd7:    rd_val = 32'(status_q);
      default: rd_val = '0;
    endcase
  end
  // One-cycle acknowledge; data only driven for reads
  always_comb begin
    ready_d = req_q;
    rdata_d = req_q && !we_q ? rd_val : '0;
  end
  // State registers
  always_ff @(posedge clock) begin
    if (reset) begin
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q   <= '0;
      dout_q   <= '0;
      dir_q    <= '0;
      ren_q    <= '0;
      fen_q    <= '0;
      status_q <= '0;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      dout_q   <= dout_d;
      dir_q    <= dir_d;
      ren_q    <= ren_d;
      fen_q    <= fen_d;
      status_q <= status_d;
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
    end
  end
endmodule
